sdi_frame_receiver: RTL and testbench

//  Serial receiver: far end of the shift-register SDO link driven by `top`.

---
 rtl/sdi_frame_receiver.sv | 146 ++++++++++++++
 tb/tb_sdi_frame_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdi_frame_receiver.sv
// Serial frame receiver: synchronizes the SDI line, recovers start/data/stop frames (MSB first)
// and presents each word on a valid/ready port with framing-error and overrun pulses.
module sdi_frame_receiver #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BIT_DIV     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SDI_signal_in,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_VALID,
  input  logic              DATA_READY,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  output logic              BUSY
);

  localparam int unsigned CntW = $clog2(BIT_DIV);
  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BIT_DIV / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BIT_DIV - 1);
  localparam logic [BitW-1:0] WordLast = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  sdi_s;
  logic                  stop_ok, stop_bad;

  assign sdi_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sdi_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          // Start bit still low at its centre; a high line here was a glitch.
          cnt_d   = '0;
          state_d = sdi_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {shift_q[DATA_W-2:0], sdi_s};
          if (bit_q == WordLast) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (sdi_s) begin
            stop_ok = 1'b1;
            state_d = StIdle;
          end else begin
            stop_bad = 1'b1;
            state_d  = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (sdi_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;
    if (valid_q && DATA_READY) valid_d = 1'b0;
    if (stop_ok) begin
      // A word being accepted on this edge frees the slot for the new one.
      if (!valid_q || DATA_READY) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      sync_q      <= '1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], SDI_signal_in};
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign FRAME_ERR  = frame_err_q;
  assign OVERRUN    = overrun_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_sdi_frame_receiver.sv
// Directed bench for sdi_frame_receiver: drives framed serial words and checks delivered words,
// flag pulses, latency and handshake behaviour against an expected-word queue.
module tb_sdi_frame_receiver;

  localparam int unsigned DataW = 8;
  localparam int unsigned BitDiv = 16;
  localparam int unsigned SyncStages = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sdi = 1'b1;
  logic             ready = 1'b0;
  logic [DataW-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  sdi_frame_receiver #(
    .DATA_W     (DataW),
    .BIT_DIV    (BitDiv),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .SDI_signal_in(sdi),
    .DATA_OUT     (data),
    .DATA_VALID   (valid),
    .DATA_READY   (ready),
    .FRAME_ERR    (frame_err),
    .OVERRUN      (overrun),
    .BUSY         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int words_seen = 0;
  logic [DataW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare: every transfer must match the next expected word in order.
  logic             prev_valid;
  logic             prev_xfer;
  logic [DataW-1:0] prev_data;
  logic [DataW-1:0] exp_word;
  initial begin
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected word: got %0h, required none", data);
          end else begin
            exp_word = exp_q.pop_front();
            check("word", 32'(data), 32'(exp_word));
            words_seen++;
          end
        end
        if (prev_valid && !prev_xfer) begin
          check("valid held", 32'(valid), 32'd1);
          check("data stable", 32'(data), 32'(prev_data));
        end
        if (frame_err) fe_seen++;
        if (overrun) ov_seen++;
        if (frame_err || overrun) check("flags exclusive", 32'(frame_err & overrun), 32'd0);
        prev_valid = valid;
        prev_xfer  = valid && ready;
        prev_data  = data;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    wait_cyc(BitDiv);
  endtask

  // Sends one frame; lat = cycles into the stop bit at which VALID first rises (-1 if never).
  task automatic send_frame(input logic [DataW-1:0] d, input logic stop, output int lat);
    logic was;
    lat = -1;
    send_bit(1'b0);
    for (int i = DataW - 1; i >= 0; i--) send_bit(d[i]);
    sdi = stop;
    was = valid;
    for (int k = 1; k <= int'(BitDiv); k++) begin
      wait_cyc(1);
      if (lat < 0 && valid && !was) lat = k;
      was = valid;
    end
    sdi = 1'b1;
  endtask

  int lat;
  int fe0;
  int ov0;
  int ret;
  logic saw_busy;

  initial begin
    // Reset state.
    #120;
    check("reset valid", 32'(valid), 32'd0);
    check("reset data", 32'(data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset flags", 32'({frame_err, overrun}), 32'd0);
    rst_n = 1'b1;
    wait_cyc(4);

    // 1: single frame; VALID 3 cycles after mid-stop on the line = cycle 11 of the stop bit.
    ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, lat);
    check("t1 latency", 32'(lat), 32'd11);
    wait_cyc(4);
    check("t1 words", 32'(words_seen), 32'd1);
    check("t1 flags", 32'(fe_seen + ov_seen), 32'd0);

    // 2: back-to-back frames with zero idle.
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, lat);
    send_frame(8'hC3, 1'b1, lat);
    wait_cyc(4);
    check("t2 words", 32'(words_seen), 32'd3);
    check("t2 queue drained", 32'(exp_q.size()), 32'd0);

    // 3: low stop bit, then a clean frame.
    fe0 = fe_seen;
    send_frame(8'h55, 1'b0, lat);
    check("t3 no valid", 32'(lat), 32'hFFFF_FFFF);
    wait_cyc(20);
    check("t3 frame_err", 32'(fe_seen - fe0), 32'd1);
    check("t3 valid low", 32'(valid), 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, lat);
    wait_cyc(4);
    check("t3 words", 32'(words_seen), 32'd4);

    // 4: overrun with consumer stalled.
    ready = 1'b0;
    ov0 = ov_seen;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, lat);
    send_frame(8'h22, 1'b1, lat);
    wait_cyc(4);
    check("t4 valid held", 32'(valid), 32'd1);
    check("t4 data held", 32'(data), 32'h11);
    check("t4 overrun", 32'(ov_seen - ov0), 32'd1);
    ready = 1'b1;
    wait_cyc(1);
    check("t4 valid drops", 32'(valid), 32'd0);
    check("t4 words", 32'(words_seen), 32'd5);

    // 5: 3-cycle glitch on an idle line.
    fe0 = fe_seen;
    ov0 = ov_seen;
    saw_busy = 1'b0;
    ret = -1;
    sdi = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      wait_cyc(1);
      if (k == 3) sdi = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (saw_busy && !busy && ret < 0) ret = k;
    end
    check("t5 busy seen", 32'(saw_busy), 32'd1);
    check("t5 busy bounded", 32'(ret > 0 && ret <= int'(BitDiv / 2 + SyncStages + 1)), 32'd1);
    check("t5 no flags", 32'((fe_seen - fe0) + (ov_seen - ov0)), 32'd0);
    check("t5 no word", 32'(words_seen), 32'd5);

    // 6: reset mid-frame, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    wait_cyc(1);
    check("t6 reset outputs", 32'({data, valid, frame_err, overrun, busy}), 32'd0);
    wait_cyc(2);
    sdi = 1'b1;
    rst_n = 1'b1;
    wait_cyc(20);
    check("t6 idle after reset", 32'(busy), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, lat);
    wait_cyc(4);
    check("t6 words", 32'(words_seen), 32'd6);
    check("t6 queue drained", 32'(exp_q.size()), 32'd0);
    check("total frame_err", 32'(fe_seen), 32'd1);
    check("total overrun", 32'(ov_seen), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
